silly_function: RTL and testbench
=================================

# silly_function

Three-input combinational Boolean function with a small clocked observation wrapper. Output `y` is the sum-of-minterms function y = a'b'c' + ab'c' + ab'c, which simplifies to y = b'(a + c'). It sits as a leaf datapath cell; the registered output and counters let downstream logic and benches see the result one cycle later and measure how often it is asserted.

## Interface
- `COUNT_W`, default 32: width of the two statistics counters (minimum 2).

- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `a`  input  1  function input (MSB of minterm index).
- `b`  input  1  function input.
- `c`  input  1  function input (LSB of minterm index).
- `y`  output  1  combinational function result.
- `y_q`  output  1  `y` registered on the rising edge of `clk`.
- `idx_q`  output  3  registered minterm index {a,b,c}.
- `eval_count`  output  COUNT_W  rising edges since reset, excluding reset cycles.
- `ones_count`  output  COUNT_W  rising edges since reset on which `y` was 1.

One clock; reset is synchronous and active-high.

## Operation
- Truth table for {a,b,c} → y: 000→1, 001→0, 010→0, 011→0, 100→1, 101→1, 110→0, 111→0.
- `y` is purely combinational from `a`, `b`, `c`. It is unaffected by `clk` and `reset`, including while `reset` is high.
- Any X/Z on an input that can affect the result drives `y` to X. Do not mask it with a default case.
- On each rising edge with `reset` low:
  - `y_q` ← y.
  - `idx_q` ← {a,b,c}.
  - `eval_count` ← eval_count + 1.
  - `ones_count` ← ones_count + 1 if y is 1.
- Both counters saturate at all-ones and never wrap.
- `ones_count` ≤ `eval_count` always holds.
- On a rising edge with `reset` high:
  - `y_q` ← 0, `idx_q` ← 000.
  - `eval_count` ← 0, `ones_count` ← 0.
  - Reset has priority over any simultaneous update.
- Reset asserted mid-operation clears all registered state on the next edge. Counting resumes on the first edge with `reset` low.
- No handshake. Inputs are sampled every cycle.

## Timing
- `y`: zero-cycle latency, combinational settle only. It must be valid within the same half-cycle inputs change, e.g. inputs applied shortly after a rising edge and checked at the falling edge.
- `y_q`, `idx_q`: one-cycle latency, reflecting inputs present at the capturing rising edge.
- Counters: the value after edge N includes the sample taken at edge N.
- Reset values, all outputs except `y`: `y_q`=0, `idx_q`=000, `eval_count`=0, `ones_count`=0. Before the first reset edge these outputs are undefined.

## Test plan
- Exhaustive, clock running, `reset` low after 27 time units:
  - Apply each {a,b,c} 000…111 after a rising edge; check `y` at the falling edge → 1,0,0,0,1,1,0,0.
  - Report a total error count of 0 after the 8 vectors.
- Registered path: drive 100 then 110 on consecutive cycles → `y_q` reads 1 then 0, one cycle after each; `idx_q` reads 100 then 110.
- Counters: after reset, apply all 8 vectors once each → `eval_count`=8 and `ones_count`=3.
- Saturation, `COUNT_W`=4: hold abc=000 for 20 cycles → both counters stick at 15.
- Reset mid-run:
  - Assert `reset` for one edge after 5 counted cycles → all registered outputs 0 on that edge.
  - `y` keeps tracking inputs during reset.
  - Counting restarts from 1 on the next edge.
- X propagation: a=X, b=0, c=1 → `y`=X; a=X, b=1 → `y`=0.

Source files
------------

// File: rtl/silly_function.sv
// Leaf Boolean cell y = b'(a + c') with a registered copy, the captured minterm index,
// and saturating counters of evaluations and asserted results.
module silly_function #(
   parameter int unsigned COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               a,
   input  logic               b,
   input  logic               c,
   output logic               y,
   output logic               y_q,
   output logic [2:0]         idx_q,
   output logic [COUNT_W-1:0] eval_count,
   output logic [COUNT_W-1:0] ones_count
);

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

   logic               y_d;
   logic [2:0]         idx_d;
   logic [COUNT_W-1:0] eval_q;
   logic [COUNT_W-1:0] eval_d;
   logic [COUNT_W-1:0] ones_q;
   logic [COUNT_W-1:0] ones_d;
   logic               yq_q;
   logic [2:0]         idx_reg_q;

   // Bitwise form keeps X on a relevant input visible on y instead of masking it.
   assign y = ~b & (a | ~c);

   always_comb begin
      y_d    = y;
      idx_d  = {a, b, c};
      eval_d = eval_q;
      ones_d = ones_q;
      if (eval_q != CNT_MAX) begin
         eval_d = eval_q + CNT_ONE;
      end
      // Ones only advances alongside eval, so ones_count can never overtake it.
      if ((y == 1'b1) && (ones_q != CNT_MAX)) begin
         ones_d = ones_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         yq_q      <= 1'b0;
         idx_reg_q <= 3'b000;
         eval_q    <= '0;
         ones_q    <= '0;
      end else begin
         yq_q      <= y_d;
         idx_reg_q <= idx_d;
         eval_q    <= eval_d;
         ones_q    <= ones_d;
      end
   end

   assign y_q        = yq_q;
   assign idx_q      = idx_reg_q;
   assign eval_count = eval_q;
   assign ones_count = ones_q;

endmodule

// File: tb/tb_silly_function.sv
// Directed bench for silly_function: truth table, registered path, counters,
// saturation on a narrow instance, mid-run reset and X propagation.
module tb_silly_function;

   logic        clk;
   logic        reset;
   logic        a, b, c;
   logic        y, y_q;
   logic [2:0]  idx_q;
   logic [31:0] eval_count, ones_count;

   logic        reset_s;
   logic        a_s, b_s, c_s;
   logic        y_s, y_q_s;
   logic [2:0]  idx_q_s;
   logic [3:0]  eval_s, ones_s;

   int n_pass  = 0;
   int n_total = 0;
   int exh_err = 0;

   logic [7:0] tt_exp = 8'b0011_0001;  // bit i = y for {a,b,c}=i

   silly_function #(.COUNT_W(32)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
      .y(y), .y_q(y_q), .idx_q(idx_q),
      .eval_count(eval_count), .ones_count(ones_count)
   );

   silly_function #(.COUNT_W(4)) dut_sat (
      .clk(clk), .reset(reset_s), .a(a_s), .b(b_s), .c(c_s),
      .y(y_s), .y_q(y_q_s), .idx_q(idx_q_s),
      .eval_count(eval_s), .ones_count(ones_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      reset = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
      reset_s = 1'b1; a_s = 1'b0; b_s = 1'b0; c_s = 1'b0;

      // reset edges at 5 and 15; sample at 20
      #20;
      chk("rst_y_q", {31'b0, y_q}, 32'd0);
      chk("rst_idx_q", {29'b0, idx_q}, 32'd0);
      chk("rst_eval", eval_count, 32'd0);
      chk("rst_ones", ones_count, 32'd0);
      #7;
      reset = 1'b0;

      // exhaustive truth table on combinational y
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #2;
         {a, b, c} = 3'(i);
         @(negedge clk);
         if (y !== tt_exp[i]) exh_err++;
         chk($sformatf("tt_%0d", i), {31'b0, y}, {31'b0, tt_exp[i]});
      end
      chk("exh_errors", exh_err, 32'd0);
      chk("ones_le_eval", {31'b0, ones_count <= eval_count}, 32'd1);

      // registered path
      @(posedge clk); #2;
      {a, b, c} = 3'b100;
      @(posedge clk); #2;
      {a, b, c} = 3'b110;
      @(negedge clk);
      chk("reg_y_q_100", {31'b0, y_q}, 32'd1);
      chk("reg_idx_100", {29'b0, idx_q}, 32'b100);
      @(posedge clk);
      @(negedge clk);
      chk("reg_y_q_110", {31'b0, y_q}, 32'd0);
      chk("reg_idx_110", {29'b0, idx_q}, 32'b110);

      // counters: reset, then each vector once
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         {a, b, c} = 3'(i);
         @(posedge clk); #2;
         if (i == 0) chk("cnt_first_eval", eval_count, 32'd1);
      end
      chk("cnt_eval_8", eval_count, 32'd8);
      chk("cnt_ones_3", ones_count, 32'd3);

      // reset mid-run after 5 counted cycles
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      {a, b, c} = 3'b100;
      repeat (5) begin
         @(posedge clk); #2;
      end
      chk("mid_eval_5", eval_count, 32'd5);
      chk("mid_ones_5", ones_count, 32'd5);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_y_q", {31'b0, y_q}, 32'd0);
      chk("mid_rst_idx", {29'b0, idx_q}, 32'd0);
      chk("mid_rst_eval", eval_count, 32'd0);
      chk("mid_rst_ones", ones_count, 32'd0);
      {a, b, c} = 3'b101;
      #1;
      chk("rst_y_track_101", {31'b0, y}, 32'd1);
      {a, b, c} = 3'b011;
      #1;
      chk("rst_y_track_011", {31'b0, y}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("restart_eval_1", eval_count, 32'd1);
      chk("restart_ones_0", ones_count, 32'd0);
      chk("restart_idx", {29'b0, idx_q}, 32'b011);

      // saturation on the 4-bit instance, abc=000 held
      @(posedge clk); #2;
      reset_s = 1'b1;
      @(posedge clk); #2;
      reset_s = 1'b0;
      chk("sat_rst_eval", {28'b0, eval_s}, 32'd0);
      repeat (14) begin
         @(posedge clk); #2;
      end
      chk("sat_eval_14", {28'b0, eval_s}, 32'd14);
      chk("sat_ones_14", {28'b0, ones_s}, 32'd14);
      repeat (6) begin
         @(posedge clk); #2;
      end
      chk("sat_eval_15", {28'b0, eval_s}, 32'd15);
      chk("sat_ones_15", {28'b0, ones_s}, 32'd15);

      // X propagation
      a = 1'bx; b = 1'b0; c = 1'b1;
      #1;
      chk("x_a_b0c1", {31'b0, y}, {31'b0, 1'bx});
      b = 1'b1;
      #1;
      chk("x_a_b1", {31'b0, y}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
